// File: rtl/minipit_spi_cfg.sv
// rtl/minipit_spi_cfg.sv - SPI mode-0 configuration front-end for the mini PIT timer
module minipit_spi_cfg #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] status_in,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_prev_q, cs_prev_q;
    logic sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q, mosi_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] cmd_q, cmd_d;
    logic       wr_en_q, wr_en_d;
    logic [1:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_err_q, frame_err_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Bring the asynchronous SPI pins into the clk domain; cs_n idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    // Registered edge detect; mosi is delayed alongside so it lines up with the rise pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            mosi_q      <= mosi_s;
        end
    end

    assign rx_next = {rx_sh_q[6:0], mosi_q};

    // Frame sequencing: command byte, data byte, then wait for cs_n to release
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        cmd_d       = cmd_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall_q) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            CMD: begin
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sclk_rise_q) begin
                    rx_sh_d   = rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_d   = rx_next;
                        state_d = DATA;
                        // Read: preload status so bit 7 is on miso before the 9th rise
                        if (!rx_next[7]) begin
                            tx_sh_d = status_in;
                            miso_d  = status_in[7];
                        end
                    end
                end
            end
            DATA: begin
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    // Mode 0: change miso on the falling edge, presenting the current MSB
                    if (sclk_fall_q && !cmd_q[7]) begin
                        miso_d  = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                    if (sclk_rise_q) begin
                        rx_sh_d   = rx_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = DONE;
                            if (cmd_q[7]) begin
                                if (cmd_q[1:0] != 2'b11) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cmd_q[1:0];
                                    wr_data_d = rx_next;
                                end else begin
                                    frame_err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'd0;
            tx_sh_q     <= 8'd0;
            cmd_q       <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 2'd0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            cmd_q       <= cmd_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign miso      = miso_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/minipit_spi_cfg.md
Name: minipit_spi_cfg

Overview:
Serial configuration front-end for the mini PIT timer. It receives 16-bit SPI mode-0 frames from an external host and converts them into the timer's single-cycle register-write strobe (write enable, 2-bit config address, 8-bit data). It can also shift the timer's 8-bit status byte back to the host. It sits directly upstream of the timer's config write port and lets the timer be configured over 3–4 pins instead of a parallel bus.

Parameters:
SYNC_STAGES, 2, number of flops in each synchronizer on sclk, cs_n and mosi (legal range 2..3)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sclk  input  1  SPI clock from host, asynchronous to clk; must be ≤ clk/4
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  SPI data from host, MSB first
miso  output  1  SPI data to host, registered
status_in  input  8  timer status byte, sampled for read frames
wr_en  output  1  one-cycle write strobe to the timer
wr_addr  output  2  timer config address (00 = config, 01 = count high, 10 = count low)
wr_data  output  8  write data
frame_err  output  1  one-cycle pulse on a malformed or rejected frame
busy  output  1  high while a frame is in progress (state ≠ IDLE)

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, miso=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, and all shift registers 0. Synchronizer flops reset cs_n to 1 and sclk/mosi to 0.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. A one-flop history of synced sclk gives rise/fall detect; a history of synced cs_n gives fall/rise detect. mosi is sampled from its synced value on a detected sclk rise.
- Frame format: byte 0 is the command, byte 1 is data, both MSB first.
  - Command bit 7: 1 = write, 0 = read.
  - Command bits 1:0: addr.
  - Command bits 6:2: ignored.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - cs_n fall → CMD, bit_cnt=0.
  - sclk edges are ignored.
- CMD:
  - Each sclk rise shifts mosi into rx_sh and increments bit_cnt (3-bit, wraps).
  - On the 8th rise: latch cmd = {rx_sh[6:0], mosi} and go to DATA.
  - If cmd[7]=0, load tx_sh=status_in in that same cycle.
- DATA:
  - Each sclk rise shifts mosi into rx_sh.
  - For read frames, each sclk fall shifts tx_sh left and drives miso=tx_sh[7].
  - miso shows status_in[7] from the cycle after the load, so the host samples bit 7 on the 9th rise.
  - On the 8th data rise, go to DONE. For write frames with addr≠11:
    - wr_en=1 for exactly one cycle, in the cycle after that rise is detected.
    - In that same cycle, wr_addr=cmd[1:0] and wr_data={rx_sh[6:0], mosi}.
  - wr_addr and wr_data hold their values until the next write.
  - addr=11 write: no wr_en; frame_err pulses in the cycle wr_en would have.
  - A read frame never asserts wr_en.
- DONE:
  - Extra sclk edges are ignored.
  - cs_n rise → IDLE.
  - miso=0.
- Aborted frame: cs_n rise while in CMD or DATA → IDLE, no wr_en, frame_err=1 for one cycle, bit_cnt cleared.
- Latency: a 16th sclk rise first sampled by the synchronizer on clk edge N gives wr_en high in the cycle after edge N+SYNC_STAGES+1.
- miso is 0 whenever synced cs_n=1 or the frame is a write.
- Simultaneous cs_n rise and sclk rise detected in the same cycle: cs_n wins. That sclk rise is dropped, so a frame whose 16th rise coincides with its cs_n rise is aborted.
- cs_n fall while in DONE is impossible, since cs_n must rise first. A fall detected in IDLE in the same cycle as an sclk rise starts CMD, and that sclk rise is not counted.
- Reset mid-frame: everything returns to reset values. The frame in progress produces no wr_en and no frame_err. The next cs_n fall starts a fresh frame.
- Back-to-back frames: cs_n high for ≥ SYNC_STAGES+1 clk cycles between frames is required. A shorter gap may be missed (undefined).

Test Plan:
- Write frame: cmd 0x81, data 0xA5 at sclk=clk/8 → one wr_en pulse with wr_addr=01, wr_data=0xA5; frame_err stays 0.
- Read frame: cmd 0x00 with status_in=0x84 → miso bits on sclk rises 9..16 are 1,0,0,0,0,1,0,0; wr_en never asserts.
- Aborted frame: cs_n rises after 11 sclk rises → frame_err pulses once, no wr_en, busy drops to 0, state returns to IDLE.
- Reserved address: cmd 0x83, data 0xFF → no wr_en, one frame_err pulse, wr_addr/wr_data keep their previous values.
- Extra clocks and back-to-back frames:
  - 20 sclk rises in one frame (cmd 0x80, data 0xC0) → exactly one wr_en, with wr_data=0xC0.
  - A following frame (cmd 0x82, data 0x10) → second wr_en with wr_addr=10, wr_data=0x10.
- Reset mid-frame: assert reset after 5 data bits, release it, then send a full frame (cmd 0x81, data 0x3C) → only one wr_en, with wr_data=0x3C.
